laplace_line_feeder: RTL

Producer side of the Laplace filter's three-line input interface. Accepts a raw image as a stream of 64-bit pixel words (8 pixels/word) from the host/DMA path. Keeps a rolling three-line window in internal line banks and delivers each window on the `line1`/`line2`/`line3` valid/ack ports. Drives `o_filter` so the downstream `laplace_top` processes one output line per window.

---
 rtl/laplace_line_feeder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/laplace_line_feeder.sv
// Rolling three-line window feeder for the Laplace filter: primes three line banks from the pixel
// stream, replays each window downstream word by word, then refills the oldest bank while filtering.
module laplace_line_feeder #(
   parameter int WORDS_PER_LINE  = 64,
   parameter int LINES_PER_FRAME = 512
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_pix_data_valid,
   input  logic [63:0] i_pix_data,
   output logic        o_pix_data_ack,
   output logic        o_line1_data_valid,
   output logic        o_line2_data_valid,
   output logic        o_line3_data_valid,
   output logic [63:0] o_line1_data,
   output logic [63:0] o_line2_data,
   output logic [63:0] o_line3_data,
   input  logic        i_line1_data_ack,
   input  logic        i_line2_data_ack,
   input  logic        i_line3_data_ack,
   output logic        o_filter,
   input  logic        i_line_done,
   output logic        o_frame_done
);
   localparam int AW = $clog2(WORDS_PER_LINE);
   localparam int WW = $clog2(LINES_PER_FRAME);
   localparam logic [AW-1:0] LAST_WORD = AW'(WORDS_PER_LINE - 1);
   localparam logic [WW-1:0] LAST_WIN  = WW'(LINES_PER_FRAME - 3);

   typedef enum logic [2:0] {IDLE, PRIME, SEND, FILTER, GAP} state_t;
   state_t state, state_nxt;

   logic [63:0]   bank0 [WORDS_PER_LINE];
   logic [63:0]   bank1 [WORDS_PER_LINE];
   logic [63:0]   bank2 [WORDS_PER_LINE];
   logic [63:0]   rd0, rd1, rd2;
   logic [AW-1:0] word_cnt;
   logic [1:0]    prime_line;
   logic [1:0]    ptr;
   logic [WW-1:0] win_cnt;
   logic          done_flag, fill_done, send_last, out_vld;
   logic          last_win, in_xfer, out_xfer, issue, last_fill, done_now, fill_ok;
   logic [1:0]    wr_bank;

   assign last_win  = (win_cnt == LAST_WIN);
   assign o_pix_data_ack = (state == PRIME) || (state == FILTER && !last_win && !fill_done);
   assign in_xfer   = i_pix_data_valid && o_pix_data_ack;
   assign out_xfer  = out_vld && i_line1_data_ack && i_line2_data_ack && i_line3_data_ack;
   assign issue     = (state == SEND) && !send_last && (!out_vld || out_xfer);
   assign last_fill = in_xfer && (word_cnt == LAST_WORD);
   assign done_now  = done_flag || i_line_done;
   assign fill_ok   = last_win || fill_done || last_fill;
   assign wr_bank   = (state == PRIME) ? prime_line : ptr;

   assign o_line1_data_valid = out_vld;
   assign o_line2_data_valid = out_vld;
   assign o_line3_data_valid = out_vld;

   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt    = state;
      o_filter     = 1'b0;
      o_frame_done = 1'b0;
      case (state)
         IDLE:   state_nxt = PRIME;
         PRIME:  if (in_xfer && prime_line == 2'd2 && word_cnt == LAST_WORD) state_nxt = SEND;
         SEND:   if (out_xfer && send_last) state_nxt = FILTER;
         FILTER: begin
            o_filter = 1'b1;
            if (done_now && fill_ok) state_nxt = GAP;
         end
         GAP: begin
            o_frame_done = last_win;
            state_nxt    = last_win ? PRIME : SEND;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Banks are plain RAM: written from the stream, read one word per issue.
   always_ff @(posedge i_clk) begin
      if (in_xfer) begin
         case (wr_bank)
            2'd0:    bank0[word_cnt] <= i_pix_data;
            2'd1:    bank1[word_cnt] <= i_pix_data;
            default: bank2[word_cnt] <= i_pix_data;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         word_cnt   <= '0;
         prime_line <= 2'd0;
         ptr        <= 2'd0;
         win_cnt    <= '0;
         done_flag  <= 1'b0;
         fill_done  <= 1'b0;
         send_last  <= 1'b0;
         out_vld    <= 1'b0;
         rd0        <= '0;
         rd1        <= '0;
         rd2        <= '0;
      end else begin
         if (in_xfer) begin
            word_cnt <= word_cnt + 1'b1;
            if (state == PRIME && word_cnt == LAST_WORD)
               prime_line <= (prime_line == 2'd2) ? 2'd0 : prime_line + 2'd1;
            if (state == FILTER && word_cnt == LAST_WORD)
               fill_done <= 1'b1;
         end
         // A new read is issued only when the output register is empty or draining,
         // so a partial ack simply freezes rd0..rd2.
         if (issue) begin
            word_cnt  <= word_cnt + 1'b1;
            send_last <= (word_cnt == LAST_WORD);
            out_vld   <= 1'b1;
            rd0       <= bank0[word_cnt];
            rd1       <= bank1[word_cnt];
            rd2       <= bank2[word_cnt];
         end else if (out_xfer) begin
            out_vld   <= 1'b0;
            send_last <= 1'b0;
         end
         if (state == FILTER && i_line_done) done_flag <= 1'b1;
         if (state == GAP) begin
            done_flag <= 1'b0;
            fill_done <= 1'b0;
            if (last_win) begin
               ptr     <= 2'd0;
               win_cnt <= '0;
            end else begin
               ptr     <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
               win_cnt <= win_cnt + 1'b1;
            end
         end
      end
   end

   // ptr names the oldest bank: oldest -> line1, then line2, newest -> line3.
   always_comb begin
      o_line1_data = rd0;
      o_line2_data = rd1;
      o_line3_data = rd2;
      case (ptr)
         2'd1: begin
            o_line1_data = rd1;
            o_line2_data = rd2;
            o_line3_data = rd0;
         end
         2'd2: begin
            o_line1_data = rd2;
            o_line2_data = rd0;
            o_line3_data = rd1;
         end
         default: ;
      endcase
   end
endmodule
